// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bus of the two-port data memory arbiter.
// The arbiter uses the slave modport; the requesters plus the memory use master.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH_POW = 6,
  parameter int unsigned ADDR_WIDTH_POW = 6
);
  localparam int unsigned DW = 2 ** DATA_WIDTH_POW;
  localparam int unsigned AW = 2 ** ADDR_WIDTH_POW;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_readEnable;
  logic            mem_writeEnable;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
           mem_addr, mem_wdata, mem_readEnable, mem_writeEnable
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
           mem_addr, mem_wdata, mem_readEnable, mem_writeEnable
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared data memory port:
// port 0 = core load/store, port 1 = debug/DMA, one access in flight.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH_POW = 6,
  parameter int unsigned ADDR_WIDTH_POW = 6,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic          busy
);
  localparam int unsigned DW = 2 ** DATA_WIDTH_POW;
  localparam int unsigned AW = 2 ** ADDR_WIDTH_POW;
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       owner;
  logic       wr_q;
  logic [3:0] lat_cnt;
  logic       grant_vld;
  logic       grant_port;

  // Grant is suppressed while rst_n is low so req_ready reads 0 during reset.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    if (state == IDLE && rst_n) begin
      case (bus.req_valid)
        2'b01: begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end
        2'b10: begin
          grant_vld  = 1'b1;
          grant_port = 1'b1;
        end
        2'b11: begin
          grant_vld  = 1'b1;
          grant_port = rr_ptr;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant_vld ? (grant_port ? 2'b10 : 2'b01) : '0;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt           = state;
    bus.mem_readEnable  = 1'b0;
    bus.mem_writeEnable = 1'b0;
    bus.resp_valid      = '0;
    unique case (state)
      IDLE: begin
        if (grant_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.mem_writeEnable = wr_q;
        bus.mem_readEnable  = ~wr_q;
        state_nxt           = wr_q ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = owner ? 2'b10 : 2'b01;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_wdata are loaded at the handshake, so they present the
  // registered request during ISSUE and hold it until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= 1'b0;
      owner          <= 1'b0;
      wr_q           <= 1'b0;
      lat_cnt        <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        owner         <= grant_port;
        rr_ptr        <= ~grant_port;
        wr_q          <= grant_port ? bus.req_write[1] : bus.req_write[0];
        bus.mem_addr  <= grant_port ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        bus.mem_wdata <= grant_port ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT) begin
        if (lat_cnt == '0) bus.resp_rdata <= bus.mem_rdata;
        else               lat_cnt        <= lat_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LATENCY 3 and 4), each with a
// behavioural memory whose read data is only valid READ_LATENCY cycles after the strobe.
module tb_dmem_arbiter;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int RL_A = 3;
  localparam int RL_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, busy_a, busy_b, mem_clr;
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_arbiter_if #(.DATA_WIDTH_POW(6), .ADDR_WIDTH_POW(6)) bus_a ();
  dmem_arbiter_if #(.DATA_WIDTH_POW(6), .ADDR_WIDTH_POW(6)) bus_b ();

  dmem_arbiter #(.DATA_WIDTH_POW(6), .ADDR_WIDTH_POW(6), .READ_LATENCY(RL_A)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a), .busy(busy_a));
  dmem_arbiter #(.DATA_WIDTH_POW(6), .ADDR_WIDTH_POW(6), .READ_LATENCY(RL_B)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b), .busy(busy_b));

  // Memories are indexed by addr[5:0]; unrelated cycles return random junk.
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] pipe_a [RL_A];
  logic [DW-1:0] pipe_b [RL_B];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= '0;
    end else if (bus_a.mem_writeEnable) begin
      mem_a[bus_a.mem_addr[5:0]] <= bus_a.mem_wdata;
    end
    pipe_a[0] <= bus_a.mem_readEnable ? mem_a[bus_a.mem_addr[5:0]] : {$urandom, $urandom};
    for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign bus_a.mem_rdata = pipe_a[RL_A-1];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= '0;
    end else if (bus_b.mem_writeEnable) begin
      mem_b[bus_b.mem_addr[5:0]] <= bus_b.mem_wdata;
    end
    pipe_b[0] <= bus_b.mem_readEnable ? mem_b[bus_b.mem_addr[5:0]] : {$urandom, $urandom};
    for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign bus_b.mem_rdata = pipe_b[RL_B-1];

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.req_valid = 2'b11; bus_a.req_write = 2'b01;
    bus_a.req_addr  = {$urandom, $urandom, $urandom, $urandom};
    bus_a.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    bus_b.req_valid = 2'b11; bus_b.req_write = 2'b10;
    bus_b.req_addr  = {$urandom, $urandom, $urandom, $urandom};
    bus_b.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    n_checks++; if (bus_a.req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", bus_a.req_ready); else n_pass++;
    n_checks++; if (bus_a.resp_valid !== 2'b00) $display("FAIL rst_resp_valid: got %b expected 00", bus_a.resp_valid); else n_pass++;
    n_checks++; if (bus_a.resp_rdata !== 64'd0) $display("FAIL rst_resp_rdata: got %h expected 0", bus_a.resp_rdata); else n_pass++;
    n_checks++; if (bus_a.mem_addr !== 64'd0) $display("FAIL rst_mem_addr: got %h expected 0", bus_a.mem_addr); else n_pass++;
    n_checks++; if (bus_a.mem_wdata !== 64'd0) $display("FAIL rst_mem_wdata: got %h expected 0", bus_a.mem_wdata); else n_pass++;
    n_checks++; if ({bus_a.mem_readEnable, bus_a.mem_writeEnable} !== 2'b00) $display("FAIL rst_enables: got %b%b expected 00", bus_a.mem_readEnable, bus_a.mem_writeEnable); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_a); else n_pass++;
    n_checks++; if ({busy_b, bus_b.req_ready, bus_b.resp_valid} !== 5'b0) $display("FAIL rst_b_outputs: got %b expected 00000", {busy_b, bus_b.req_ready, bus_b.resp_valid}); else n_pass++;
    bus_a.req_valid = 2'b00;
    bus_b.req_valid = 2'b00;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    mem_clr = 1'b0;
  endtask

  task automatic test_write_p0();
    @(negedge clk);
    bus_a.req_valid = 2'b01; bus_a.req_write = 2'b01;
    bus_a.req_addr  = {{$urandom, $urandom}, 64'h10};
    bus_a.req_wdata = {{$urandom, $urandom}, 64'hDEADBEEF};
    #1;
    n_checks++; if (bus_a.req_ready !== 2'b01) $display("FAIL wr_ready_T: got %b expected 01", bus_a.req_ready); else n_pass++;
    @(negedge clk);
    bus_a.req_valid = 2'b11;
    bus_a.req_addr  = {$urandom, $urandom, $urandom, $urandom};
    bus_a.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    n_checks++; if ({bus_a.mem_writeEnable, bus_a.mem_readEnable} !== 2'b10) $display("FAIL wr_enables_T1: got %b%b expected 10", bus_a.mem_writeEnable, bus_a.mem_readEnable); else n_pass++;
    n_checks++; if (bus_a.mem_addr !== 64'h10) $display("FAIL wr_mem_addr: got %h expected 10", bus_a.mem_addr); else n_pass++;
    n_checks++; if (bus_a.mem_wdata !== 64'hDEADBEEF) $display("FAIL wr_mem_wdata: got %h expected deadbeef", bus_a.mem_wdata); else n_pass++;
    n_checks++; if (bus_a.req_ready !== 2'b00) $display("FAIL wr_ready_T1: got %b expected 00", bus_a.req_ready); else n_pass++;
    @(negedge clk);
    bus_a.req_valid = 2'b00;
    #1;
    n_checks++; if (bus_a.resp_valid !== 2'b01) $display("FAIL wr_resp_T2: got %b expected 01", bus_a.resp_valid); else n_pass++;
    n_checks++; if (bus_a.mem_writeEnable !== 1'b0) $display("FAIL wr_we_T2: got %b expected 0", bus_a.mem_writeEnable); else n_pass++;
    n_checks++; if (bus_a.resp_rdata !== 64'd0) $display("FAIL wr_rdata_hold: got %h expected 0", bus_a.resp_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy_a, bus_a.resp_valid} !== 3'b000) $display("FAIL wr_idle_T3: got %b expected 000", {busy_a, bus_a.resp_valid}); else n_pass++;
    n_checks++; if (mem_a[16] !== 64'hDEADBEEF) $display("FAIL wr_mem_content: got %h expected deadbeef", mem_a[16]); else n_pass++;
  endtask

  task automatic test_read_p1();
    @(negedge clk);
    bus_a.req_valid = 2'b10; bus_a.req_write = 2'b00;
    bus_a.req_addr  = {64'h10, {$urandom, $urandom}};
    #1;
    n_checks++; if (bus_a.req_ready !== 2'b10) $display("FAIL rd_ready_T: got %b expected 10", bus_a.req_ready); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_a.req_valid = 2'b00;
      bus_a.req_addr  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_checks++; if (bus_a.mem_readEnable !== (k == 1)) $display("FAIL rd_re_T%0d: got %b expected %b", k, bus_a.mem_readEnable, k == 1); else n_pass++;
      n_checks++; if (busy_a !== (k <= 5)) $display("FAIL rd_busy_T%0d: got %b expected %b", k, busy_a, k <= 5); else n_pass++;
      n_checks++; if (bus_a.resp_valid !== ((k == 5) ? 2'b10 : 2'b00)) $display("FAIL rd_resp_T%0d: got %b", k, bus_a.resp_valid); else n_pass++;
      if (k == 1) begin
        n_checks++; if (bus_a.mem_addr !== 64'h10) $display("FAIL rd_mem_addr: got %h expected 10", bus_a.mem_addr); else n_pass++;
      end
      if (k == 5) begin
        n_checks++; if (bus_a.resp_rdata !== 64'hDEADBEEF) $display("FAIL rd_rdata: got %h expected deadbeef", bus_a.resp_rdata); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      a = 64'h20 + 64'(c);
      bus_a.req_valid = (c <= 8) ? 2'b01 : 2'b00;
      bus_a.req_write = 2'b11;
      bus_a.req_addr  = {64'h0, a};
      bus_a.req_wdata = {64'h0, a ^ 64'hA5A5};
      #1;
      n_checks++; if (bus_a.req_ready !== ((c % 3 == 0 && c <= 8) ? 2'b01 : 2'b00)) $display("FAIL b2b_ready_c%0d: got %b", c, bus_a.req_ready); else n_pass++;
      n_checks++; if (bus_a.mem_writeEnable !== (c % 3 == 1)) $display("FAIL b2b_we_c%0d: got %b", c, bus_a.mem_writeEnable); else n_pass++;
      if (c % 3 == 1) begin
        n_checks++; if (bus_a.mem_addr !== a - 64'd1) $display("FAIL b2b_addr_c%0d: got %h expected %h", c, bus_a.mem_addr, a - 64'd1); else n_pass++;
      end
    end
    n_checks++; if (busy_a !== 1'b0) $display("FAIL b2b_busy_end: got %b expected 0", busy_a); else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_resp;
    @(negedge clk);
    bus_a.req_valid = 2'b01; bus_a.req_write = 2'b01;
    bus_a.req_addr  = {64'h10, 64'h40};
    bus_a.req_wdata = {64'h0, 64'h1234};
    #1;
    n_checks++; if (bus_a.req_ready !== 2'b01) $display("FAIL cont_ready_c0: got %b expected 01", bus_a.req_ready); else n_pass++;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus_a.req_valid = (c <= 3) ? 2'b11 : 2'b00;
      #1;
      if (c <= 3) begin
        n_checks++; if (bus_a.req_ready !== ((c == 3) ? 2'b10 : 2'b00)) $display("FAIL cont_ready_c%0d: got %b", c, bus_a.req_ready); else n_pass++;
      end
      exp_resp = (c == 2) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
      n_checks++; if (bus_a.resp_valid !== exp_resp) $display("FAIL cont_resp_c%0d: got %b expected %b", c, bus_a.resp_valid, exp_resp); else n_pass++;
      if (c == 8) begin
        n_checks++; if (bus_a.resp_rdata !== 64'hDEADBEEF) $display("FAIL cont_rdata: got %h expected deadbeef", bus_a.resp_rdata); else n_pass++;
      end
    end
  endtask

  task automatic test_alternation();
    bit grants[$];
    int resp_cnt [2];
    int cyc;
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    @(negedge clk);
    rst_a_n = 1'b0; bus_a.req_valid = 2'b00;
    @(negedge clk);
    rst_a_n = 1'b1;
    cyc = 0;
    while ((resp_cnt[0] + resp_cnt[1] < 8) && cyc < 120) begin
      @(negedge clk);
      bus_a.req_valid = (grants.size() < 8) ? 2'b11 : 2'b00;
      bus_a.req_write = 2'b00;
      bus_a.req_addr  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (bus_a.req_ready == 2'b01) grants.push_back(1'b0);
      if (bus_a.req_ready == 2'b10) grants.push_back(1'b1);
      if (bus_a.resp_valid[0] === 1'b1) resp_cnt[0]++;
      if (bus_a.resp_valid[1] === 1'b1) resp_cnt[1]++;
      cyc++;
    end
    n_checks++; if (grants.size() != 8) $display("FAIL alt_grant_count: got %0d expected 8", grants.size()); else n_pass++;
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++; if (grants[k] !== k[0]) $display("FAIL alt_order_%0d: got %0d expected %0d", k, grants[k], k[0]); else n_pass++;
    end
    n_checks++; if (resp_cnt[0] != 4) $display("FAIL alt_resp_p0: got %0d expected 4", resp_cnt[0]); else n_pass++;
    n_checks++; if (resp_cnt[1] != 4) $display("FAIL alt_resp_p1: got %0d expected 4", resp_cnt[1]); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    bus_b.req_valid = 2'b10; bus_b.req_write = 2'b10;
    bus_b.req_addr  = {64'h20, 64'h0};
    bus_b.req_wdata = {64'h0123_4567_89AB_CDEF, 64'h0};
    #1;
    n_checks++; if (bus_b.req_ready !== 2'b10) $display("FAIL rw_wr_ready: got %b expected 10", bus_b.req_ready); else n_pass++;
    @(negedge clk);
    bus_b.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    bus_b.req_valid = 2'b01; bus_b.req_write = 2'b00;
    bus_b.req_addr  = {64'h0, 64'h20};
    #1;
    n_checks++; if (bus_b.req_ready !== 2'b01) $display("FAIL rw_rd_ready: got %b expected 01", bus_b.req_ready); else n_pass++;
    @(negedge clk);
    bus_b.req_valid = 2'b00;
    #1;
    n_checks++; if (bus_b.mem_readEnable !== 1'b1) $display("FAIL rw_re: got %b expected 1", bus_b.mem_readEnable); else n_pass++;
    repeat (2) @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    #1;
    n_checks++; if ({busy_b, bus_b.mem_readEnable, bus_b.resp_valid} !== 4'b0) $display("FAIL rw_after_rst: got %b expected 0000", {busy_b, bus_b.mem_readEnable, bus_b.resp_valid}); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++; if (bus_b.resp_valid !== 2'b00) $display("FAIL rw_no_resp_%0d: got %b expected 00", k, bus_b.resp_valid); else n_pass++;
    end
    bus_b.req_valid = 2'b01;
    #1;
    n_checks++; if (bus_b.req_ready !== 2'b01) $display("FAIL rw_retry_ready: got %b expected 01", bus_b.req_ready); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_b.req_valid = 2'b00;
      #1;
      n_checks++; if (bus_b.resp_valid !== ((k == 6) ? 2'b01 : 2'b00)) $display("FAIL rw_retry_resp_T%0d: got %b", k, bus_b.resp_valid); else n_pass++;
      if (k == 6) begin
        n_checks++; if (bus_b.resp_rdata !== 64'h0123_4567_89AB_CDEF) $display("FAIL rw_retry_rdata: got %h expected 0123456789abcdef", bus_b.resp_rdata); else n_pass++;
      end
    end
  endtask

  // Reference: an accepted request at cycle c strobes memory at c+1 and
  // responds at c+2 (write) or c+2+RL (read); the next grant is possible one cycle later.
  task automatic test_random_traffic();
    logic [DW-1:0] ref_mem [64];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [AW-1:0] m_addr, exp_addr;
    logic [DW-1:0] m_wdata, exp_wdata, exp_rdata, pend_rdata;
    logic [1:0]    v, w, exp_ready, exp_resp;
    bit            rr, g, m_port, m_wr, exp_busy;
    int            free_at, en_cyc, resp_cyc;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    @(negedge clk);
    rst_a_n = 1'b0; mem_clr = 1'b1; bus_a.req_valid = 2'b00;
    @(negedge clk);
    rst_a_n = 1'b1; mem_clr = 1'b0;
    rr = 1'b0; free_at = 0; en_cyc = -1; resp_cyc = -1;
    m_port = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0; pend_rdata = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        a[p] = {$urandom, 26'd0, 6'($urandom_range(0, 63))};
        d[p] = {$urandom, $urandom};
      end
      bus_a.req_valid = v; bus_a.req_write = w;
      bus_a.req_addr  = {a[1], a[0]};
      bus_a.req_wdata = {d[1], d[0]};
      #1;
      exp_busy  = (c < free_at);
      exp_ready = 2'b00;
      if (!exp_busy && v != 2'b00) begin
        g = (v == 2'b11) ? rr : v[1];
        exp_ready = g ? 2'b10 : 2'b01;
        rr = ~g;
        m_port = g; m_wr = w[g]; m_addr = a[g]; m_wdata = d[g];
        en_cyc = c + 1;
        if (m_wr) begin
          resp_cyc = c + 2; free_at = c + 3;
          ref_mem[m_addr[5:0]] = m_wdata;
        end else begin
          resp_cyc = c + 2 + RL_A; free_at = c + 3 + RL_A;
          pend_rdata = ref_mem[m_addr[5:0]];
        end
      end
      if (c == en_cyc) begin
        exp_addr = m_addr; exp_wdata = m_wdata;
      end
      if (c == resp_cyc && !m_wr) exp_rdata = pend_rdata;
      exp_resp = (c == resp_cyc) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      n_checks++; if (bus_a.req_ready !== exp_ready) $display("FAIL rnd_ready_c%0d: got %b expected %b", c, bus_a.req_ready, exp_ready); else n_pass++;
      n_checks++; if (busy_a !== exp_busy) $display("FAIL rnd_busy_c%0d: got %b expected %b", c, busy_a, exp_busy); else n_pass++;
      n_checks++; if (bus_a.mem_writeEnable !== (c == en_cyc && m_wr)) $display("FAIL rnd_we_c%0d: got %b", c, bus_a.mem_writeEnable); else n_pass++;
      n_checks++; if (bus_a.mem_readEnable !== (c == en_cyc && !m_wr)) $display("FAIL rnd_re_c%0d: got %b", c, bus_a.mem_readEnable); else n_pass++;
      n_checks++; if (bus_a.mem_addr !== exp_addr) $display("FAIL rnd_addr_c%0d: got %h expected %h", c, bus_a.mem_addr, exp_addr); else n_pass++;
      n_checks++; if (bus_a.mem_wdata !== exp_wdata) $display("FAIL rnd_wdata_c%0d: got %h expected %h", c, bus_a.mem_wdata, exp_wdata); else n_pass++;
      n_checks++; if (bus_a.resp_valid !== exp_resp) $display("FAIL rnd_resp_c%0d: got %b expected %b", c, bus_a.resp_valid, exp_resp); else n_pass++;
      n_checks++; if (bus_a.resp_rdata !== exp_rdata) $display("FAIL rnd_rdata_c%0d: got %h expected %h", c, bus_a.resp_rdata, exp_rdata); else n_pass++;
    end
    bus_a.req_valid = 2'b00;
    repeat (RL_A + 4) @(negedge clk);
  endtask

  initial begin
    mem_clr = 1'b1;
    bus_a.req_valid = '0; bus_a.req_write = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_write = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    test_reset();
    test_write_p0();
    test_read_p1();
    test_back_to_back();
    test_contention();
    test_alternation();
    test_reset_in_wait();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
